// File: rtl/axi_eth_ofm_buf.sv
// axi_eth_ofm_buf: store-and-forward egress frame buffer toward the 10G MAC.
// Oversize frames are cut, flagged on tuser at the last beat, and counted.
module axi_eth_ofm_buf #(
  parameter int C_DEPTH     = 512,
  parameter int C_MAX_BEATS = 1200,
  parameter int C_FCNT_W    = 10
) (
  input  logic                tx_clk,
  input  logic                tx_reset_n,
  input  logic [63:0]         mac_tdata,
  input  logic [7:0]          mac_tkeep,
  input  logic                mac_tlast,
  input  logic                mac_tvalid,
  output logic                mac_tready,
  output logic [63:0]         tx_axis_mac_tdata,
  output logic [7:0]          tx_axis_mac_tkeep,
  output logic                tx_axis_mac_tlast,
  output logic                tx_axis_mac_tuser,
  output logic                tx_axis_mac_tvalid,
  input  logic                tx_axis_mac_tready,
  output logic [C_FCNT_W-1:0] frame_cnt,
  output logic [31:0]         tx_frames,
  output logic [15:0]         trunc_frames
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int BW = $clog2(C_MAX_BEATS + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(C_DEPTH);
  localparam logic [BW-1:0] MAXB1 = BW'(C_MAX_BEATS - 1);
  localparam logic [C_FCNT_W-1:0] FMAX = '1;

  typedef enum logic {
    ACCEPT,
    DISCARD
  } in_st_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } out_st_e;

  in_st_e  in_q, in_d;
  out_st_e out_q, out_d;

  logic                run_q;
  logic [BW-1:0]       beat_q, beat_d;
  logic [15:0]         trunc_q, trunc_d;
  logic [31:0]         txf_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         words_q, words_d;
  logic [C_FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [73:0] mem [C_DEPTH];
  logic [73:0] head;
  logic [73:0] wr_word;

  logic        in_rdy, in_hs;
  logic        wr, wr_last, wr_err;
  logic        ld, done, out_hs;

  logic [63:0] odata_q;
  logic [7:0]  okeep_q;
  logic        olast_q, ouser_q;

  assign in_rdy = run_q & ((in_q == DISCARD) |
                  ((words_q < DEPTH_W) & (fcnt_q != FMAX)));
  assign in_hs   = mac_tvalid & in_rdy;
  assign out_hs  = (out_q == SEND) & tx_axis_mac_tready;
  assign wr_word = {wr_err, wr_last, mac_tkeep, mac_tdata};
  assign head    = mem[rptr_q];

  // Ingress FSM: write beats, cut frames at the beat limit, drop the tail.
  always_comb begin
    in_d    = in_q;
    beat_d  = beat_q;
    trunc_d = trunc_q;
    wr      = 1'b0;
    wr_last = 1'b0;
    wr_err  = 1'b0;
    unique case (in_q)
      ACCEPT: begin
        if (in_hs) begin
          wr = 1'b1;
          if (mac_tlast) begin
            wr_last = 1'b1;
            beat_d  = '0;
          end else if (beat_q == MAXB1) begin
            wr_last = 1'b1;
            wr_err  = 1'b1;
            beat_d  = '0;
            trunc_d = trunc_q + 16'd1;
            in_d    = DISCARD;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DISCARD: begin
        if (in_hs && mac_tlast) begin
          in_d   = ACCEPT;
          beat_d = '0;
        end
      end
      default: in_d = ACCEPT;
    endcase
  end

  // Egress FSM: wait for a whole frame, prime the output regs, stream it.
  always_comb begin
    out_d = out_q;
    ld    = 1'b0;
    done  = 1'b0;
    unique case (out_q)
      IDLE: begin
        if (fcnt_q != '0) out_d = LOAD;
      end
      LOAD: begin
        ld    = 1'b1;
        out_d = SEND;
      end
      SEND: begin
        if (out_hs) begin
          if (olast_q) begin
            done  = 1'b1;
            out_d = IDLE;
          end else begin
            ld = 1'b1;
          end
        end
      end
      default: out_d = IDLE;
    endcase
  end

  // Occupancy and complete-frame bookkeeping.
  always_comb begin
    words_d = words_q;
    fcnt_d  = fcnt_q;
    if (wr && !ld) words_d = words_q + (AW+1)'(1);
    else if (!wr && ld) words_d = words_q - (AW+1)'(1);
    if ((wr && wr_last) && !done) fcnt_d = fcnt_q + C_FCNT_W'(1);
    else if (!(wr && wr_last) && done) fcnt_d = fcnt_q - C_FCNT_W'(1);
  end

  // Data storage; flushed by pointer reset, contents need no reset.
  always_ff @(posedge tx_clk) begin
    if (wr) mem[wptr_q] <= wr_word;
  end

  // State, pointers, output registers and statistics.
  always_ff @(posedge tx_clk or negedge tx_reset_n) begin
    if (!tx_reset_n) begin
      run_q   <= 1'b0;
      in_q    <= ACCEPT;
      out_q   <= IDLE;
      beat_q  <= '0;
      trunc_q <= '0;
      txf_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      words_q <= '0;
      fcnt_q  <= '0;
      odata_q <= '0;
      okeep_q <= '0;
      olast_q <= 1'b0;
      ouser_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      in_q    <= in_d;
      out_q   <= out_d;
      beat_q  <= beat_d;
      trunc_q <= trunc_d;
      words_q <= words_d;
      fcnt_q  <= fcnt_d;
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (ld) begin
        rptr_q  <= rptr_q + AW'(1);
        odata_q <= head[63:0];
        okeep_q <= head[71:64];
        olast_q <= head[72];
        ouser_q <= head[73] & head[72];
      end
      if (done) txf_q <= txf_q + 32'd1;
    end
  end

  assign mac_tready         = in_rdy;
  assign tx_axis_mac_tdata  = odata_q;
  assign tx_axis_mac_tkeep  = okeep_q;
  assign tx_axis_mac_tlast  = olast_q;
  assign tx_axis_mac_tuser  = ouser_q;
  assign tx_axis_mac_tvalid = (out_q == SEND);
  assign frame_cnt          = fcnt_q;
  assign tx_frames          = txf_q;
  assign trunc_frames       = trunc_q;

endmodule
